truth_table_sweeper: RTL and testbench

//  Sequencer that drives an N-input, 1-output combinational gate (NAND4 variants etc.) through all 2^N input codes.

---
 rtl/truth_table_sweeper_pkg.sv | 22 ++
 rtl/truth_table_sweeper_if.sv | 47 ++++
 rtl/truth_table_sweeper_settle_counter.sv | 35 +++
 rtl/truth_table_sweeper.sv | 137 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// +--------------------------------------------------------------------------+
// | sweep_pkg: FSM state encoding and shared constants for the sweeper.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sweep_pkg;

  localparam int MAX_SETTLE = 15;
  localparam int SETTLE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

endpackage : sweep_pkg

`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
// +--------------------------------------------------------------------------+
// | truth_table_sweeper_if: harness <-> sweeper <-> gate signal bundle.      |
// | Optional capture vector present when SWEEP_CAPTURE_EN is defined.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface truth_table_sweeper_if #(
  parameter int N_IN = 4
) ();

  logic                 i_start;
  logic                 i_abort;
  logic [2**N_IN-1:0]   i_expected;
  logic                 i_duv_out;
  logic [N_IN-1:0]      o_duv_in;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic [N_IN:0]        o_fail_cnt;
  logic [N_IN-1:0]      o_first_fail_idx;
  logic                 o_first_fail_vld;
`ifdef SWEEP_CAPTURE_EN
  logic [2**N_IN-1:0]   o_captured;
`endif

  modport master (
    output i_start, i_abort, i_expected, i_duv_out,
    input  o_duv_in, o_busy, o_done, o_pass, o_fail_cnt,
           o_first_fail_idx, o_first_fail_vld
`ifdef SWEEP_CAPTURE_EN
    , input o_captured
`endif
  );

  modport slave (
    input  i_start, i_abort, i_expected, i_duv_out,
    output o_duv_in, o_busy, o_done, o_pass, o_fail_cnt,
           o_first_fail_idx, o_first_fail_vld
`ifdef SWEEP_CAPTURE_EN
    , output o_captured
`endif
  );

endinterface : truth_table_sweeper_if

`default_nettype wire

// File: rtl/truth_table_sweeper_settle_counter.sv
// +--------------------------------------------------------------------------+
// | settle_counter: loadable down-counter timing the per-code settle window. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module settle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] cnt_q;

  // o_zero flags the cycle whose closing edge takes the count to zero.
  assign o_zero = i_en && (cnt_q == WIDTH'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

endmodule : settle_counter

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// +--------------------------------------------------------------------------+
// | truth_table_sweeper: walks a gate through all 2^N_IN codes and checks    |
// | its output against a truth-table vector. Option: SWEEP_CAPTURE_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  truth_table_sweeper_if.slave  bus
);

  sweep_state_e     state_q;
  logic [N_IN-1:0]  idx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [N_IN:0]    fail_cnt_q;
  logic [N_IN-1:0]  first_fail_idx_q;
  logic             first_fail_vld_q;
`ifdef SWEEP_CAPTURE_EN
  logic [2**N_IN-1:0] captured_q;
`endif

  logic w_settle_zero;
  logic w_mismatch;
  logic w_last;

  assign w_mismatch = (bus.i_duv_out != bus.i_expected[idx_q]);
  assign w_last     = &idx_q;

  settle_counter #(
    .WIDTH (SETTLE_W)
  ) u_settle (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (state_q == ST_APPLY),
    .i_load_val (SETTLE_W'(SETTLE_CYCLES)),
    .i_en       (state_q == ST_SETTLE),
    .o_zero     (w_settle_zero)
  );

  // Outputs are registered; done/pass/busy change on the same edge that enters DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_cnt_q       <= '0;
      first_fail_idx_q <= '0;
      first_fail_vld_q <= 1'b0;
`ifdef SWEEP_CAPTURE_EN
      captured_q       <= '0;
`endif
    end else if (state_q == ST_IDLE) begin
      if (bus.i_start) begin
        state_q          <= ST_APPLY;
        idx_q            <= '0;
        busy_q           <= 1'b1;
        done_q           <= 1'b0;
        pass_q           <= 1'b0;
        fail_cnt_q       <= '0;
        first_fail_idx_q <= '0;
        first_fail_vld_q <= 1'b0;
`ifdef SWEEP_CAPTURE_EN
        captured_q       <= '0;
`endif
      end
    end else if (bus.i_abort) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_APPLY: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_settle_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            fail_cnt_q <= fail_cnt_q + (N_IN+1)'(1);
            if (!first_fail_vld_q) begin
              first_fail_idx_q <= idx_q;
              first_fail_vld_q <= 1'b1;
            end
          end
`ifdef SWEEP_CAPTURE_EN
          captured_q[idx_q] <= bus.i_duv_out;
`endif
          if (w_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_q == '0) && !w_mismatch;
          end else begin
            idx_q   <= idx_q + N_IN'(1);
            state_q <= ST_APPLY;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_duv_in         = idx_q;
  assign bus.o_busy           = busy_q;
  assign bus.o_done           = done_q;
  assign bus.o_pass           = pass_q;
  assign bus.o_fail_cnt       = fail_cnt_q;
  assign bus.o_first_fail_idx = first_fail_idx_q;
  assign bus.o_first_fail_vld = first_fail_vld_q;
`ifdef SWEEP_CAPTURE_EN
  assign bus.o_captured       = captured_q;
`endif

endmodule : truth_table_sweeper

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// +--------------------------------------------------------------------------+
// | tb_truth_table_sweeper: directed bench for truth_table_sweeper with a    |
// | NAND4 gate model and stuck-at variants. Option: SWEEP_CAPTURE_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_truth_table_sweeper;

  localparam int N_IN          = 4;
  localparam int SETTLE_CYCLES = 2;

  logic clk;
  logic rst;
  int   gate_mode;   // 0 = correct NAND4, 1 = stuck at 1, 2 = stuck at 0
  int   n_checks;
  int   n_errors;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus ();

  truth_table_sweeper #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.i_duv_out = 1'b0;
    case (gate_mode)
      0:       bus.i_duv_out = ~&bus.o_duv_in;
      1:       bus.i_duv_out = 1'b1;
      default: bus.i_duv_out = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Full sweep; edge 0 is the start-sampling edge, done expected after edge 64.
  task automatic run_sweep(input int mode, input int exp_fail, input int exp_first,
                           input int exp_vld, input int exp_pass, input int exp_cap);
    gate_mode = mode;
    start_pulse();
    chk("start_busy", 32'(bus.o_busy), 32'd1);
    chk("code0", 32'(bus.o_duv_in), 32'd0);
    for (int e = 1; e <= 64; e++) begin
      tick();
      if ((e % 4 == 0) && (e < 64)) chk("code_seq", 32'(bus.o_duv_in), 32'(e / 4));
      if (e == 63) chk("done_early", 32'(bus.o_done), 32'd0);
    end
    chk("done_at_64", 32'(bus.o_done), 32'd1);
    chk("busy_at_done", 32'(bus.o_busy), 32'd0);
    chk("pass", 32'(bus.o_pass), 32'(exp_pass));
    chk("fail_cnt", 32'(bus.o_fail_cnt), 32'(exp_fail));
    chk("first_idx", 32'(bus.o_first_fail_idx), 32'(exp_first));
    chk("first_vld", 32'(bus.o_first_fail_vld), 32'(exp_vld));
    chk("duv_in_hold", 32'(bus.o_duv_in), 32'd15);
`ifdef SWEEP_CAPTURE_EN
    chk("captured", 32'(bus.o_captured), 32'(exp_cap));
`else
    if (exp_cap < 0) chk("cap_arg", 32'(exp_cap), 32'd0);
`endif
    tick();
    chk("done_pulse_end", 32'(bus.o_done), 32'd0);
    chk("pass_held", 32'(bus.o_pass), 32'(exp_pass));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_duv_in"}, 32'(bus.o_duv_in), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.o_pass), 32'd0);
    chk({tag, "_fail"}, 32'(bus.o_fail_cnt), 32'd0);
    chk({tag, "_fidx"}, 32'(bus.o_first_fail_idx), 32'd0);
    chk({tag, "_fvld"}, 32'(bus.o_first_fail_vld), 32'd0);
  endtask

  initial begin
    logic seen_done;
    n_checks       = 0;
    n_errors       = 0;
    gate_mode      = 0;
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_abort    = 1'b0;
    bus.i_expected = 16'h7FFF;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("rst");

    // abort in IDLE has no effect
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("idle_abort_busy", 32'(bus.o_busy), 32'd0);

    run_sweep(0, 0, 0, 0, 1, 32'h7FFF);
    run_sweep(1, 1, 15, 1, 0, 32'hFFFF);
    run_sweep(2, 15, 0, 1, 0, 32'h0000);

    // start and abort together in IDLE: start wins
    gate_mode   = 0;
    bus.i_abort = 1'b1;
    start_pulse();
    bus.i_abort = 1'b0;
    chk("start_wins", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // abort sampled at edge 21 of a sweep
    start_pulse();
    repeat (20) tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    chk("abort_pass", 32'(bus.o_pass), 32'd0);
    chk("abort_fail", 32'(bus.o_fail_cnt), 32'd0);
    chk("abort_hold", 32'(bus.o_duv_in), 32'd5);
    seen_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      seen_done = seen_done | bus.o_done | bus.o_busy;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // start re-pulsed at edge 30 ignored, reset at edge 40
    start_pulse();
    repeat (29) tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("restart_ignored", 32'(bus.o_duv_in), 32'd7);
    chk("restart_busy", 32'(bus.o_busy), 32'd1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midrst");
    run_sweep(0, 0, 0, 0, 1, 32'h7FFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_truth_table_sweeper

`default_nettype wire
